// File: rtl/cpe_lsu.sv
// ============================================================================
// Module      : cpe_lsu
// Description : Multi-cycle load/store unit with lane alignment, extension,
//               misalign/illegal-size detection and bus timeout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpe_lsu #(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk_w_i,
    input  logic                res_w_i_l,
    input  logic                lsu_req_w_i_h,
    input  logic                lsu_we_w_i_h,
    input  logic [2:0]          funct_3_w_i,
    input  logic [ADDR_W-1:0]   addr_w_i,
    input  logic [XLEN-1:0]     wr_data_w_i,
    output logic                stall_w_o_h,
    output logic                done_w_o_h,
    output logic [XLEN-1:0]     rd_data_w_o,
    output logic [1:0]          err_w_o,
    output logic                mem_req_w_o_h,
    output logic                mem_we_w_o_h,
    output logic [ADDR_W-1:0]   mem_addr_w_o,
    output logic [XLEN/8-1:0]   mem_be_w_o,
    output logic [XLEN-1:0]     mem_wr_data_w_o,
    input  logic                mem_ack_w_i_h,
    input  logic [XLEN-1:0]     mem_rd_data_w_i
);

    localparam int c_BYTES = XLEN / 8;
    localparam int c_OFF_W = $clog2(c_BYTES);
    localparam int c_CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_BUSY = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_next;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_we;
    logic [2:0]         r_funct3;
    logic [ADDR_W-1:0]  r_addr;
    logic [c_BYTES-1:0] r_be;
    logic [XLEN-1:0]    r_wdata;
    logic [c_OFF_W-1:0] r_off;
    logic [XLEN-1:0]    r_rd_data;
    logic [1:0]         r_err;

    logic [3:0]         w_nbytes;
    logic [c_OFF_W-1:0] w_off;
    logic [c_OFF_W-1:0] w_lo_mask;
    logic               w_illegal;
    logic               w_misalign;
    logic [1:0]         w_err;
    logic [c_BYTES-1:0] w_be_base;
    logic [c_BYTES-1:0] w_be;
    logic [XLEN-1:0]    w_wdata_sh;
    logic [XLEN-1:0]    w_wdata;
    logic [ADDR_W-1:0]  w_addr_al;

    logic [XLEN-1:0]    w_rd_shift;
    logic [6:0]         w_load_bits;
    logic               w_sign;
    logic               w_sign_fill;
    logic [XLEN-1:0]    w_load;

    // Request decode; the size mask is taken modulo the word so an oversize
    // access only matters through the illegal flag, which has priority.
    always_comb begin
        w_nbytes   = 4'd1 << funct_3_w_i[1:0];
        w_off      = addr_w_i[c_OFF_W-1:0];
        w_lo_mask  = w_nbytes[c_OFF_W-1:0] - c_OFF_W'(1);
        w_illegal  = (funct_3_w_i == 3'b111) | (lsu_we_w_i_h & funct_3_w_i[2]) |
                     (int'(w_nbytes) > c_BYTES);
        w_misalign = |(w_off & w_lo_mask);
        w_err      = w_illegal ? 2'b10 : (w_misalign ? 2'b01 : 2'b00);
        w_be_base  = '0;
        for (int b = 0; b < c_BYTES; b++) begin
            w_be_base[b] = (b < int'(w_nbytes));
        end
        w_be       = w_be_base << w_off;
        w_wdata_sh = wr_data_w_i << {w_off, 3'b000};
        w_wdata    = '0;
        for (int b = 0; b < c_BYTES; b++) begin
            w_wdata[8*b +: 8] = w_be[b] ? w_wdata_sh[8*b +: 8] : 8'h00;
        end
        w_addr_al  = {addr_w_i[ADDR_W-1:c_OFF_W], {c_OFF_W{1'b0}}};
    end

    always_comb begin
        w_rd_shift  = mem_rd_data_w_i >> {r_off, 3'b000};
        w_load_bits = 7'd8 << r_funct3[1:0];
        case (r_funct3[1:0])
            2'b00:   w_sign = w_rd_shift[7];
            2'b01:   w_sign = w_rd_shift[15];
            2'b10:   w_sign = w_rd_shift[31];
            default: w_sign = w_rd_shift[XLEN-1];
        endcase
        w_sign_fill = w_sign & ~r_funct3[2];
        w_load      = '0;
        for (int i = 0; i < XLEN; i++) begin
            w_load[i] = (i < int'(w_load_bits)) ? w_rd_shift[i] : w_sign_fill;
        end
    end

    always_ff @(posedge clk_w_i or negedge res_w_i_l) begin
        if (!res_w_i_l) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (lsu_req_w_i_h) begin
                    w_next = (w_err != 2'b00) ? c_ST_DONE : c_ST_BUSY;
                end
            end
            c_ST_BUSY: begin
                if (mem_ack_w_i_h || (r_cnt == c_CNT_LAST)) begin
                    w_next = c_ST_DONE;
                end
            end
            c_ST_DONE: w_next = c_ST_IDLE;
            default:   w_next = c_ST_IDLE;
        endcase
    end

    always_comb begin
        mem_req_w_o_h = (r_state == c_ST_BUSY);
        done_w_o_h    = (r_state == c_ST_DONE);
        stall_w_o_h   = ((r_state == c_ST_IDLE) & lsu_req_w_i_h) | (r_state == c_ST_BUSY);
    end

    // Access context is captured once on acceptance so the bus sees stable values.
    always_ff @(posedge clk_w_i or negedge res_w_i_l) begin
        if (!res_w_i_l) begin
            r_cnt     <= '0;
            r_we      <= 1'b0;
            r_funct3  <= 3'b000;
            r_addr    <= '0;
            r_be      <= '0;
            r_wdata   <= '0;
            r_off     <= '0;
            r_rd_data <= '0;
            r_err     <= 2'b00;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (lsu_req_w_i_h) begin
                        if (w_err != 2'b00) begin
                            r_err     <= w_err;
                            r_rd_data <= '0;
                        end else begin
                            r_we     <= lsu_we_w_i_h;
                            r_funct3 <= funct_3_w_i;
                            r_addr   <= w_addr_al;
                            r_be     <= w_be;
                            r_wdata  <= w_wdata;
                            r_off    <= w_off;
                            r_cnt    <= '0;
                        end
                    end
                end
                c_ST_BUSY: begin
                    if (mem_ack_w_i_h) begin
                        r_rd_data <= r_we ? '0 : w_load;
                        r_err     <= 2'b00;
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_rd_data <= '0;
                        r_err     <= 2'b11;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign rd_data_w_o     = r_rd_data;
    assign err_w_o         = r_err;
    assign mem_we_w_o_h    = r_we;
    assign mem_addr_w_o    = r_addr;
    assign mem_be_w_o      = r_be;
    assign mem_wr_data_w_o = r_wdata;

endmodule

`default_nettype wire

// File: tb/tb_cpe_lsu.sv
// ============================================================================
// Module      : tb_cpe_lsu
// Description : Scoreboard bench for cpe_lsu with 32- and 64-bit instances.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpe_lsu;

    typedef struct {
        bit          sel;
        logic [63:0] rd;
        logic [1:0]  err;
        bit          chk_rd;
        int          cyc;
    } exp_t;

    typedef struct {
        bit          sel;
        logic [31:0] addr;
        logic [7:0]  be;
        logic [63:0] wd;
        bit          we;
    } mexp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req32 = 1'b0, req64 = 1'b0;
    logic        we_i = 1'b0;
    logic [2:0]  f3_i = 3'b000;
    logic [31:0] addr_i = '0;
    logic [63:0] wdata_i = '0;
    logic [63:0] rword = '0;
    logic        ack32 = 1'b0, ack64 = 1'b0;

    logic        stall32, done32, mreq32, mwe32;
    logic [31:0] rd32, maddr32, mwd32;
    logic [1:0]  err32;
    logic [3:0]  be32;
    logic        stall64, done64, mreq64, mwe64;
    logic [63:0] rd64, mwd64;
    logic [31:0] maddr64;
    logic [1:0]  err64;
    logic [7:0]  be64;

    int    cyc = 0;
    int    n_vec = 0;
    int    n_fail = 0;
    exp_t  exp_q[$];
    mexp_t mq[$];
    exp_t  me;
    mexp_t mm;
    bit    pm32 = 1'b0, pm64 = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cpe_lsu #(.XLEN(32), .ADDR_W(32), .TIMEOUT(4)) u_d32 (
        .clk_w_i(clk), .res_w_i_l(rst_n), .lsu_req_w_i_h(req32), .lsu_we_w_i_h(we_i),
        .funct_3_w_i(f3_i), .addr_w_i(addr_i), .wr_data_w_i(wdata_i[31:0]),
        .stall_w_o_h(stall32), .done_w_o_h(done32), .rd_data_w_o(rd32), .err_w_o(err32),
        .mem_req_w_o_h(mreq32), .mem_we_w_o_h(mwe32), .mem_addr_w_o(maddr32),
        .mem_be_w_o(be32), .mem_wr_data_w_o(mwd32), .mem_ack_w_i_h(ack32),
        .mem_rd_data_w_i(rword[31:0])
    );

    cpe_lsu #(.XLEN(64), .ADDR_W(32), .TIMEOUT(4)) u_d64 (
        .clk_w_i(clk), .res_w_i_l(rst_n), .lsu_req_w_i_h(req64), .lsu_we_w_i_h(we_i),
        .funct_3_w_i(f3_i), .addr_w_i(addr_i), .wr_data_w_i(wdata_i),
        .stall_w_o_h(stall64), .done_w_o_h(done64), .rd_data_w_o(rd64), .err_w_o(err64),
        .mem_req_w_o_h(mreq64), .mem_we_w_o_h(mwe64), .mem_addr_w_o(maddr64),
        .mem_be_w_o(be64), .mem_wr_data_w_o(mwd64), .mem_ack_w_i_h(ack64),
        .mem_rd_data_w_i(rword)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Completion monitor: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (done32 || done64) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL spurious_done: got done32=%0b done64=%0b required none", done32, done64);
            end else begin
                me = exp_q.pop_front();
                chk("done_unit", {63'b0, done64}, {63'b0, me.sel});
                chk("done_cycle", 64'(cyc), 64'(me.cyc));
                chk("err", done64 ? {62'b0, err64} : {62'b0, err32}, {62'b0, me.err});
                if (me.chk_rd) chk("rd_data", done64 ? rd64 : {32'b0, rd32}, me.rd);
            end
        end
    end

    // Bus monitor: the first cycle of each memory request is checked.
    always @(negedge clk) begin
        if ((mreq32 && !pm32) || (mreq64 && !pm64)) begin
            if (mq.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_mem_req: got req32=%0b req64=%0b required none", mreq32, mreq64);
            end else begin
                mm = mq.pop_front();
                chk("mem_unit", {63'b0, mreq64}, {63'b0, mm.sel});
                chk("mem_addr", {32'b0, mreq64 ? maddr64 : maddr32}, {32'b0, mm.addr});
                chk("mem_be", {56'b0, mreq64 ? be64 : {4'b0, be32}}, {56'b0, mm.be});
                chk("mem_wr_data", mreq64 ? mwd64 : {32'b0, mwd32}, mm.wd);
                chk("mem_we", {63'b0, mreq64 ? mwe64 : mwe32}, {63'b0, mm.we});
            end
        end
        pm32 = mreq32;
        pm64 = mreq64;
    end

    task automatic run(input bit sel, input bit we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [63:0] wd, input logic [63:0] rw, input int waits,
                       input bit mem_go, input logic [31:0] m_addr, input logic [7:0] m_be,
                       input logic [63:0] m_wd, input logic [63:0] exp_rd, input logic [1:0] exp_err,
                       input bit chk_rd, input int lat);
        int n;
        @(negedge clk);
        we_i    = we;
        f3_i    = f3;
        addr_i  = addr;
        wdata_i = wd;
        rword   = rw;
        if (sel) req64 = 1'b1;
        else     req32 = 1'b1;
        n = cyc;
        exp_q.push_back('{sel: sel, rd: exp_rd, err: exp_err, chk_rd: chk_rd, cyc: n + lat});
        if (mem_go) mq.push_back('{sel: sel, addr: m_addr, be: m_be, wd: m_wd, we: we});
        #1 chk("stall_req", {63'b0, sel ? stall64 : stall32}, 64'd1);
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            req32 = 1'b0;
            req64 = 1'b0;
            ack32 = !sel && (waits >= 0) && (k == 1 + waits);
            ack64 =  sel && (waits >= 0) && (k == 1 + waits);
            #1 chk("stall", {63'b0, sel ? stall64 : stall32}, {63'b0, k < lat});
        end
        @(negedge clk);
        ack32 = 1'b0;
        ack64 = 1'b0;
        #1 chk("done_seen", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        #1;
        chk("rst_mem_req32", {63'b0, mreq32}, 64'd0);
        chk("rst_mem_we32", {63'b0, mwe32}, 64'd0);
        chk("rst_done32", {63'b0, done32}, 64'd0);
        chk("rst_mem_addr32", {32'b0, maddr32}, 64'd0);
        chk("rst_mem_be32", {60'b0, be32}, 64'd0);
        chk("rst_mem_wd32", {32'b0, mwd32}, 64'd0);
        chk("rst_rd32", {32'b0, rd32}, 64'd0);
        chk("rst_err32", {62'b0, err32}, 64'd0);
        chk("rst_stall32", {63'b0, stall32}, 64'd0);
        chk("rst_mem_req64", {63'b0, mreq64}, 64'd0);
        chk("rst_rd64", rd64, 64'd0);
        rst_n = 1'b1;

        // sel we f3 addr wdata rword waits | mem_go m_addr m_be m_wd | rd err chk_rd lat
        run(0, 0, 3'b000, 32'h1003, 64'h0, 64'h80FF1234, 0,  1, 32'h1000, 8'h08, 64'h0, 64'h0000_0000_FFFF_FF80, 2'b00, 1, 2);
        run(0, 1, 3'b001, 32'h2002, 64'hBEEF, 64'h0, 3,      1, 32'h2000, 8'h0C, 64'hBEEF_0000, 64'h0, 2'b00, 1, 5);
        run(0, 0, 3'b010, 32'h0006, 64'h0, 64'h0, -1,        0, 32'h0, 8'h00, 64'h0, 64'h0, 2'b01, 0, 1);
        run(0, 0, 3'b011, 32'h0100, 64'h0, 64'h0, -1,        0, 32'h0, 8'h00, 64'h0, 64'h0, 2'b10, 0, 1);
        run(1, 0, 3'b011, 32'h0008, 64'h0, 64'h1122334455667788, 0, 1, 32'h0008, 8'hFF, 64'h0, 64'h1122334455667788, 2'b00, 1, 2);
        run(0, 0, 3'b010, 32'h0010, 64'h0, 64'h12345678, -1, 1, 32'h0010, 8'h0F, 64'h0, 64'h0, 2'b11, 1, 5);
        run(0, 0, 3'b010, 32'h0010, 64'h0, 64'hCAFEF00D, 3,  1, 32'h0010, 8'h0F, 64'h0, 64'hCAFEF00D, 2'b00, 1, 5);
        run(0, 0, 3'b101, 32'h1002, 64'h0, 64'h80FF1234, 1,  1, 32'h1000, 8'h0C, 64'h0, 64'h0000_80FF, 2'b00, 1, 3);
        run(0, 0, 3'b001, 32'h1002, 64'h0, 64'h80FF1234, 0,  1, 32'h1000, 8'h0C, 64'h0, 64'hFFFF_80FF, 2'b00, 1, 2);
        run(0, 1, 3'b000, 32'h3001, 64'hFFFFFFA5, 64'h0, 0,  1, 32'h3000, 8'h02, 64'h0000_A500, 64'h0, 2'b00, 1, 2);
        run(0, 1, 3'b100, 32'h3000, 64'h55, 64'h0, -1,       0, 32'h0, 8'h00, 64'h0, 64'h0, 2'b10, 0, 1);
        run(1, 0, 3'b111, 32'h0000, 64'h0, 64'h0, -1,        0, 32'h0, 8'h00, 64'h0, 64'h0, 2'b10, 0, 1);
        run(0, 0, 3'b001, 32'h0001, 64'h0, 64'h0, -1,        0, 32'h0, 8'h00, 64'h0, 64'h0, 2'b01, 0, 1);
        run(1, 0, 3'b010, 32'h0004, 64'h0, 64'h80000000_12345678, 2, 1, 32'h0000, 8'hF0, 64'h0, 64'hFFFFFFFF_80000000, 2'b00, 1, 4);
        run(1, 0, 3'b110, 32'h0004, 64'h0, 64'h80000000_12345678, 0, 1, 32'h0000, 8'hF0, 64'h0, 64'h00000000_80000000, 2'b00, 1, 2);
        run(1, 1, 3'b011, 32'h0010, 64'h0123456789ABCDEF, 64'h0, 1, 1, 32'h0010, 8'hFF, 64'h0123456789ABCDEF, 64'h0, 2'b00, 1, 3);
        run(1, 0, 3'b011, 32'h0004, 64'h0, 64'h0, -1,        0, 32'h0, 8'h00, 64'h0, 64'h0, 2'b01, 0, 1);
        run(1, 0, 3'b100, 32'h000F, 64'h0, 64'hA100_0000_0000_0000, 0, 1, 32'h0008, 8'h80, 64'h0, 64'h0000_0000_0000_00A1, 2'b00, 1, 2);

        // Reset two cycles into BUSY: access is dropped without a done pulse.
        @(negedge clk);
        we_i   = 1'b0;
        f3_i   = 3'b010;
        addr_i = 32'h0040;
        req32  = 1'b1;
        mq.push_back('{sel: 1'b0, addr: 32'h0040, be: 8'h0F, wd: 64'h0, we: 1'b0});
        @(negedge clk);
        req32 = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("rst_async_mem_req", {63'b0, mreq32}, 64'd0);
        chk("rst_async_stall", {63'b0, stall32}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        #1 chk("rst_mq_drained", 64'(mq.size()), 64'd0);

        // Acknowledge while idle must be ignored.
        ack32 = 1'b1;
        ack64 = 1'b1;
        repeat (2) @(negedge clk);
        ack32 = 1'b0;
        ack64 = 1'b0;
        repeat (2) @(negedge clk);

        run(0, 0, 3'b010, 32'h0020, 64'h0, 64'h13579BDF, 1, 1, 32'h0020, 8'h0F, 64'h0, 64'h1357_9BDF, 2'b00, 1, 3);

        repeat (3) @(negedge clk);
        #1 chk("final_exp_q_empty", 64'(exp_q.size()), 64'd0);
        chk("final_mq_empty", 64'(mq.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
